// File: rtl/trng_pool_sampler.sv
// Round-robin sampler over NCH ring-oscillator sources: two timed samples per visit,
// von Neumann debiasing or raw bypass, LSB-first packing. Health test: `TRNG_POOL_HEALTH_EN.
module trng_pool_sampler #(
    parameter int NCH       = 5,
    parameter int NBITS     = 2048,
    parameter int MAXW      = 12,
    parameter int SETTLE    = 2,
    parameter int RCT_LIMIT = 31
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start_p,
    input  logic             bypass,
    input  logic [MAXW-1:0]  maxbits,
    input  logic [NCH-1:0]   src_y,
    output logic [NCH-1:0]   src_en,
    output logic             busy,
    output logic             done_p,
    output logic             err_p,
    output logic [NBITS-1:0] y
);
    // cnt must represent NBITS and the cnt+2 step of a bypass pair
    localparam int CW  = $clog2(NBITS + 2) + 1;
    localparam int CHW = (NCH > 1) ? $clog2(NCH) : 1;
    localparam int TW  = (SETTLE > 1) ? $clog2(SETTLE) : 1;
    localparam logic [CHW-1:0] CH_LAST = CHW'(NCH - 1);
    localparam logic [TW-1:0]  T_LAST  = TW'(SETTLE - 1);

    typedef enum logic [2:0] {IDLE, SET_A, SET_B, EVAL, DONE} state_t;

    state_t           state_reg, state_next;
    logic [CHW-1:0]   ch_reg, ch_next;
    logic [CW-1:0]    cnt_reg, cnt_next;
    logic [CW-1:0]    tgt_reg, tgt_next;
    logic [CW-1:0]    tgt_in, cnt_plus1;
    logic [TW-1:0]    tmr_reg, tmr_next;
    logic             byp_reg, byp_next;
    logic             a_reg, a_next;
    logic             b_reg, b_next;
    logic [NBITS-1:0] y_reg, y_next;
    logic             clr_y, wr_a, wr_b;
    logic             pair_same, src_sel, trip;
    logic [NCH-1:0]   ch_onehot;

    assign tgt_in    = (maxbits == '0 || 32'(maxbits) > NBITS) ? CW'(NBITS) : CW'(maxbits);
    assign cnt_plus1 = cnt_reg + CW'(1);
    assign pair_same = (a_reg == b_reg);
    assign src_sel   = src_y[ch_reg];

    genvar gi;
    generate
        for (gi = 0; gi < NCH; gi++) begin : g_onehot
            assign ch_onehot[gi] = (ch_reg == CHW'(gi));
        end

        // Per-bit write decode keeps the variable-index store free of wide shifters
        for (gi = 0; gi < NBITS; gi++) begin : g_ybit
            assign y_next[gi] = clr_y                             ? 1'b0  :
                                (wr_a && cnt_reg   == CW'(gi))    ? a_reg :
                                (wr_b && cnt_plus1 == CW'(gi))    ? b_reg :
                                                                    y_reg[gi];
        end
    endgenerate

`ifdef TRNG_POOL_HEALTH_EN
    logic [4:0] rct_reg [NCH];
    logic [5:0] rct_inc_val;
    logic       rct_clr_all, rct_bump, rct_clr;

    assign rct_inc_val = {1'b0, rct_reg[ch_reg]} + 6'd1;
    assign trip        = (state_reg == EVAL) && pair_same && (rct_inc_val >= 6'(RCT_LIMIT));
    assign err_p       = trip;
    assign rct_clr_all = (state_reg == IDLE) && start_p;
    assign rct_bump    = (state_reg == EVAL) && pair_same;
    assign rct_clr     = (state_reg == EVAL) && !pair_same;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < NCH; i++) rct_reg[i] <= '0;
        end else begin
            for (int i = 0; i < NCH; i++) begin
                if (rct_clr_all || (rct_clr && ch_reg == CHW'(i)))
                    rct_reg[i] <= '0;
                else if (rct_bump && ch_reg == CHW'(i))
                    rct_reg[i] <= rct_inc_val[4:0];
            end
        end
    end
`else
    assign trip  = 1'b0;
    assign err_p = 1'b0;
`endif

    always_comb begin
        state_next = state_reg;
        ch_next    = ch_reg;
        cnt_next   = cnt_reg;
        tgt_next   = tgt_reg;
        tmr_next   = tmr_reg;
        byp_next   = byp_reg;
        a_next     = a_reg;
        b_next     = b_reg;
        clr_y      = 1'b0;
        wr_a       = 1'b0;
        wr_b       = 1'b0;
        src_en     = '0;
        busy       = 1'b0;
        done_p     = 1'b0;
        case (state_reg)
            IDLE: begin
                if (start_p) begin
                    clr_y      = 1'b1;
                    cnt_next   = '0;
                    ch_next    = '0;
                    tmr_next   = '0;
                    byp_next   = bypass;
                    tgt_next   = tgt_in;
                    state_next = SET_A;
                end
            end
            SET_A: begin
                busy   = 1'b1;
                src_en = ch_onehot;
                if (tmr_reg == T_LAST) begin
                    a_next     = src_sel;
                    tmr_next   = '0;
                    state_next = SET_B;
                end else begin
                    tmr_next = tmr_reg + 1'b1;
                end
            end
            SET_B: begin
                busy   = 1'b1;
                src_en = ch_onehot;
                if (tmr_reg == T_LAST) begin
                    b_next     = src_sel;
                    tmr_next   = '0;
                    state_next = EVAL;
                end else begin
                    tmr_next = tmr_reg + 1'b1;
                end
            end
            EVAL: begin
                // A health trip aborts in this very cycle, so busy drops with err_p
                busy    = !trip;
                ch_next = (ch_reg == CH_LAST) ? '0 : ch_reg + 1'b1;
                if (byp_reg) begin
                    wr_a     = 1'b1;
                    wr_b     = (cnt_plus1 < tgt_reg);
                    cnt_next = wr_b ? cnt_reg + CW'(2) : cnt_plus1;
                end else if (!pair_same) begin
                    wr_a     = 1'b1;
                    cnt_next = cnt_plus1;
                end
                if (trip) begin
                    clr_y      = 1'b1;
                    state_next = IDLE;
                end else if (cnt_next == tgt_reg) begin
                    state_next = DONE;
                end else begin
                    state_next = SET_A;
                end
            end
            DONE: begin
                done_p     = 1'b1;
                state_next = IDLE;
            end
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg <= IDLE;
            ch_reg    <= '0;
            cnt_reg   <= '0;
            tgt_reg   <= '0;
            tmr_reg   <= '0;
            byp_reg   <= 1'b0;
            a_reg     <= 1'b0;
            b_reg     <= 1'b0;
            y_reg     <= '0;
        end else begin
            state_reg <= state_next;
            ch_reg    <= ch_next;
            cnt_reg   <= cnt_next;
            tgt_reg   <= tgt_next;
            tmr_reg   <= tmr_next;
            byp_reg   <= byp_next;
            a_reg     <= a_next;
            b_reg     <= b_next;
            y_reg     <= y_next;
        end
    end

    assign y = y_reg;

endmodule
